// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU encodings. Holds the decoder load/store codes,
//                the generic ENABLE/DISABLE levels and the LSU state
//                encoding used by lsu_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // Decoder load codes (is_load)
  localparam logic [2:0] LOAD_DISABLE = 3'd0;
  localparam logic [2:0] LOAD_LB      = 3'd1;
  localparam logic [2:0] LOAD_LH      = 3'd2;
  localparam logic [2:0] LOAD_LW      = 3'd3;
  localparam logic [2:0] LOAD_LBU     = 3'd4;
  localparam logic [2:0] LOAD_LHU     = 3'd5;

  // Decoder store codes (is_store)
  localparam logic [1:0] STORE_DISABLE = 2'd0;
  localparam logic [1:0] STORE_SB      = 2'd1;
  localparam logic [1:0] STORE_SH      = 2'd2;
  localparam logic [1:0] STORE_SW      = 2'd3;

  // Load/store unit sequencer states
  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational byte-lane logic for the LSU.
//                Store side: byte enables and lane-replicated write data.
//                Load side : byte/half extraction and sign/zero extension.
//  Ports       : i_store_type  store code of the op being captured
//                i_addr_lo     addr[1:0] of the op being captured
//                i_wdata       raw rs2 store data
//                o_be          store byte enables (0 when no store)
//                o_wdata_rep   lane-replicated store data
//                i_load_type   captured load code
//                i_load_lo     captured addr[1:0] of the load
//                i_rdata       raw bus read data
//                o_ldata       extended load result
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
  import cpu_pkg::*;
(
  input  logic [1:0]  i_store_type,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata_rep,
  input  logic [2:0]  i_load_type,
  input  logic [1:0]  i_load_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ldata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be        = 4'b0000;
    o_wdata_rep = 32'h0;
    case (i_store_type)
      STORE_SB: begin
        o_be        = 4'b0001 << i_addr_lo;
        o_wdata_rep = {4{i_wdata[7:0]}};
      end
      STORE_SH: begin
        // addr[0] is ignored: halves always land on an even lane pair
        o_be        = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata_rep = {2{i_wdata[15:0]}};
      end
      STORE_SW: begin
        o_be        = 4'b1111;
        o_wdata_rep = i_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = 8'h0;
    case (i_load_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_load_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_ldata = i_rdata;
    case (i_load_type)
      LOAD_LB:  o_ldata = {{24{w_byte[7]}}, w_byte};
      LOAD_LBU: o_ldata = {24'h0, w_byte};
      LOAD_LH:  o_ldata = {{16{w_half[15]}}, w_half};
      LOAD_LHU: o_ldata = {16'h0, w_half};
      default:  o_ldata = i_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_ctrl
//  Description : Sequences RV32I loads/stores onto the req/gnt/rvalid data
//                bus and stalls the pipeline until each access completes.
//                Includes lane steering (lsu_align), flush handling and a
//                bus timeout.
//  Config      : MISALIGN_TRAP_EN - when defined, misaligned half/word ops
//                raise misalign_exc instead of issuing a bus request.
//  Ports       : clk, rst_n (async, active low)
//                is_load/is_store/addr/wdata/rd  op from decode/ALU
//                flush                           kill in-flight op
//                stall                           hold upstream stages
//                wb_valid/wb_rd/wb_data          load writeback
//                bus_err, misalign_exc           one-cycle fault pulses
//                dmem_*                          data memory bus
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  is_load,
  input  logic [1:0]  is_store,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd,
  input  logic        flush,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        bus_err,
  output logic        misalign_exc,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam logic [1:0] c_IDLE = LSU_IDLE;
  localparam logic [1:0] c_REQ  = LSU_REQ;
  localparam logic [1:0] c_WAIT = LSU_WAIT;

  // Last counter value before the timeout fires, i.e. the TIMEOUT_MAX-th
  // cycle spent in REQ/WAIT.
  localparam logic [TIMEOUT_W-1:0] c_CNT_LAST = TIMEOUT_W'(TIMEOUT_MAX - 1);

  logic [1:0]           r_state, w_state_nxt;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic                 r_we;
  logic [3:0]           r_be;
  logic [29:0]          r_waddr;
  logic [31:0]          r_wdata;
  logic [4:0]           r_rd;
  logic [2:0]           r_ltype;
  logic [1:0]           r_lo;
  logic                 r_flushed;

  logic        w_load_act, w_store_act, w_op_valid, w_idle_op;
  logic        w_misalign, w_accept, w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_rep, w_ldata;

  assign w_load_act  = (is_load != LOAD_DISABLE);
  assign w_store_act = (is_store != STORE_DISABLE);
  assign w_op_valid  = w_load_act | w_store_act;
  assign w_idle_op   = (r_state == c_IDLE) & w_op_valid & ~flush;
  assign w_timeout   = (r_cnt == c_CNT_LAST);

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    w_misalign = 1'b0;
    if (w_store_act) begin
      w_misalign = ((is_store == STORE_SH) & addr[0]) |
                   ((is_store == STORE_SW) & (addr[1:0] != 2'b00));
    end else begin
      w_misalign = (((is_load == LOAD_LH) | (is_load == LOAD_LHU)) & addr[0]) |
                   ((is_load == LOAD_LW) & (addr[1:0] != 2'b00));
    end
  end
`else
  assign w_misalign = 1'b0;
`endif

  assign misalign_exc = w_idle_op & w_misalign;

  lsu_align u_align (
    .i_store_type (is_store),
    .i_addr_lo    (addr[1:0]),
    .i_wdata      (wdata),
    .o_be         (w_be),
    .o_wdata_rep  (w_wdata_rep),
    .i_load_type  (r_ltype),
    .i_load_lo    (r_lo),
    .i_rdata      (dmem_rdata),
    .o_ldata      (w_ldata)
  );

  // Completion (gnt/rvalid) has priority over the timeout in the same cycle;
  // an unaccepted request is abandoned on flush, an accepted one is not.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    stall       = 1'b0;
    wb_valid    = 1'b0;
    bus_err     = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (w_idle_op & ~w_misalign) begin
          w_accept    = 1'b1;
          stall       = 1'b1;
          w_state_nxt = c_REQ;
        end
      end
      c_REQ: begin
        if (dmem_gnt & r_we) begin
          w_state_nxt = c_IDLE;
        end else if (dmem_gnt & dmem_rvalid) begin
          wb_valid    = ~r_flushed & ~flush;
          w_state_nxt = c_IDLE;
        end else if (flush & ~dmem_gnt) begin
          w_state_nxt = c_IDLE;
        end else if (w_timeout) begin
          bus_err     = 1'b1;
          w_state_nxt = c_IDLE;
        end else begin
          stall = 1'b1;
          if (dmem_gnt) w_state_nxt = c_WAIT;
        end
      end
      c_WAIT: begin
        if (dmem_rvalid) begin
          wb_valid    = ~r_flushed & ~flush;
          w_state_nxt = c_IDLE;
        end else if (w_timeout) begin
          bus_err     = 1'b1;
          w_state_nxt = c_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_be      <= 4'b0000;
      r_waddr   <= 30'h0;
      r_wdata   <= 32'h0;
      r_rd      <= 5'd0;
      r_ltype   <= LOAD_DISABLE;
      r_lo      <= 2'b00;
      r_flushed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        // Store wins when both codes are active; reads request the full word.
        r_we      <= w_store_act;
        r_be      <= w_store_act ? w_be : 4'b1111;
        r_waddr   <= addr[31:2];
        r_wdata   <= w_wdata_rep;
        r_rd      <= rd;
        r_ltype   <= w_store_act ? LOAD_DISABLE : is_load;
        r_lo      <= addr[1:0];
        r_cnt     <= '0;
        r_flushed <= 1'b0;
      end else if (r_state != c_IDLE) begin
        r_cnt <= r_cnt + TIMEOUT_W'(1);
        if (flush) r_flushed <= 1'b1;
      end
    end
  end

  assign dmem_req   = (r_state == c_REQ);
  assign dmem_we    = dmem_req & r_we;
  assign dmem_be    = dmem_req ? r_be : 4'b0000;
  assign dmem_addr  = dmem_req ? {r_waddr, 2'b00} : 32'h0;
  assign dmem_wdata = dmem_req ? r_wdata : 32'h0;
  assign wb_rd      = r_rd;
  assign wb_data    = wb_valid ? w_ldata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_ctrl
//  Description : Scoreboard bench for lsu_ctrl. Stimulus pushes expected bus
//                requests / writebacks / fault pulses into queues; a monitor
//                pops and compares whenever the DUT presents them. A second
//                instance with TIMEOUT_MAX = 4 covers the short timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;
  import cpu_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic        chk_data;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  is_load = LOAD_DISABLE;
  logic [1:0]  is_store = STORE_DISABLE;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [4:0]  rd = 5'd0;
  logic        flush = 1'b0;
  logic        stall, wb_valid, bus_err, misalign_exc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;

  // Second instance: short timeout, bus never grants
  logic [2:0]  t_is_load = LOAD_DISABLE;
  logic [31:0] t_addr = 32'h0;
  logic        t_stall, t_wb_valid, t_bus_err, t_misalign_exc;
  logic [4:0]  t_wb_rd;
  logic [31:0] t_wb_data, t_dmem_addr, t_dmem_wdata;
  logic        t_dmem_req, t_dmem_we;
  logic [3:0]  t_dmem_be;

  int n_checks = 0;
  int n_fail   = 0;

  req_t exp_req[$];
  wb_t  exp_wb[$];
  int   exp_err_n = 0;
  int   exp_mis_n = 0;

  // Bus responder controls
  int          rsp_gnt_dly = 0;   // REQ cycles before gnt, -1 = never
  int          rsp_rv_dly  = 0;   // cycles after gnt before rvalid, 0 = same cycle
  logic [31:0] rsp_rdata   = 32'h0;

  lsu_ctrl #(.TIMEOUT_W(8), .TIMEOUT_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n), .is_load(is_load), .is_store(is_store),
    .addr(addr), .wdata(wdata), .rd(rd), .flush(flush), .stall(stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .bus_err(bus_err),
    .misalign_exc(misalign_exc), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_be(dmem_be), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  lsu_ctrl #(.TIMEOUT_W(8), .TIMEOUT_MAX(4)) dut_t4 (
    .clk(clk), .rst_n(rst_n), .is_load(t_is_load), .is_store(STORE_DISABLE),
    .addr(t_addr), .wdata(32'h0), .rd(5'd1), .flush(1'b0), .stall(t_stall),
    .wb_valid(t_wb_valid), .wb_rd(t_wb_rd), .wb_data(t_wb_data), .bus_err(t_bus_err),
    .misalign_exc(t_misalign_exc), .dmem_req(t_dmem_req), .dmem_we(t_dmem_we),
    .dmem_be(t_dmem_be), .dmem_addr(t_dmem_addr), .dmem_wdata(t_dmem_wdata),
    .dmem_gnt(1'b0), .dmem_rvalid(1'b0), .dmem_rdata(32'h0)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    req_t e;
    e.we = 1'b1; e.addr = a; e.chk_data = 1'b1; e.be = be; e.wdata = d;
    exp_req.push_back(e);
  endtask

  task automatic push_load(input logic [31:0] a, input logic [4:0] r, input logic [31:0] d, input bit wb);
    req_t e;
    wb_t  w;
    e.we = 1'b0; e.addr = a; e.chk_data = 1'b0; e.be = 4'h0; e.wdata = 32'h0;
    exp_req.push_back(e);
    if (wb) begin
      w.rd = r; w.data = d;
      exp_wb.push_back(w);
    end
  endtask

  task automatic set_bus(input int g, input int v, input logic [31:0] d);
    rsp_gnt_dly = g; rsp_rv_dly = v; rsp_rdata = d;
  endtask

  // Presents one op, holds it while stall = 1, returns the number of stalled
  // cycles. flush is pulsed in cycle fl_cyc (cycle 0 = the IDLE capture cycle).
  task automatic run_op(input logic [2:0] lt, input logic [1:0] st, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] r, input int fl_cyc,
                        output int n_stall);
    bit done = 1'b0;
    n_stall = 0;
    is_load = lt; is_store = st; addr = a; wdata = wd; rd = r;
    for (int c = 0; c < 40 && !done; c++) begin
      flush = (c == fl_cyc);
      @(negedge clk);
      if (stall) n_stall++;
      else done = 1'b1;
      @(posedge clk); #1;
    end
    flush = 1'b0; is_load = LOAD_DISABLE; is_store = STORE_DISABLE;
    addr = 32'h0; wdata = 32'h0; rd = 5'd0;
    check("op_completes", {31'h0, done}, 32'h1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Bus responder: grants after rsp_gnt_dly REQ cycles, returns read data
  // rsp_rv_dly cycles after the grant.
  initial begin
    int req_cnt = 0;
    int rv_cnt  = 0;
    forever begin
      @(posedge clk); #1;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin dmem_rvalid = 1'b1; dmem_rdata = rsp_rdata; end
      end
      if (dmem_req) begin
        if (req_cnt == rsp_gnt_dly) begin
          dmem_gnt = 1'b1;
          if (!dmem_we) begin
            if (rsp_rv_dly == 0) begin dmem_rvalid = 1'b1; dmem_rdata = rsp_rdata; end
            else rv_cnt = rsp_rv_dly;
          end
        end
        req_cnt++;
      end else begin
        req_cnt = 0;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (dmem_req) begin
        if (exp_req.size() == 0) check("req_unexpected", {31'h0, dmem_req}, 32'h0);
        else begin
          check("req_we", {31'h0, dmem_we}, {31'h0, exp_req[0].we});
          check("req_addr", dmem_addr, exp_req[0].addr);
          if (exp_req[0].chk_data) begin
            check("req_be", {28'h0, dmem_be}, {28'h0, exp_req[0].be});
            check("req_wdata", dmem_wdata, exp_req[0].wdata);
          end
          if (dmem_gnt) void'(exp_req.pop_front());
        end
      end
      if (wb_valid) begin
        if (exp_wb.size() == 0) check("wb_unexpected", {31'h0, wb_valid}, 32'h0);
        else begin
          check("wb_rd", {27'h0, wb_rd}, {27'h0, exp_wb[0].rd});
          check("wb_data", wb_data, exp_wb[0].data);
          void'(exp_wb.pop_front());
        end
      end
      if (bus_err) begin
        if (exp_err_n == 0) check("bus_err_unexpected", {31'h0, bus_err}, 32'h0);
        else exp_err_n--;
      end
      if (misalign_exc) begin
        if (exp_mis_n == 0) check("misalign_unexpected", {31'h0, misalign_exc}, 32'h0);
        else exp_mis_n--;
      end
    end
  end

  initial begin
    int ns;
    int nreq;
    bit seen;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_stall_wb", {30'h0, stall, wb_valid}, 32'h0);
    check("rst_faults", {30'h0, bus_err, misalign_exc}, 32'h0);
    check("rst_bus", {26'h0, dmem_req, dmem_we, dmem_be}, 32'h0);
    check("rst_addr", dmem_addr, 32'h0);
    check("rst_wbdata", {wb_data[31:5], wb_rd}, 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    idle(2);

    // SW, granted on first REQ cycle
    set_bus(0, 0, 32'h0);
    push_store(32'h0000_1000, 4'hF, 32'hDEAD_BEEF);
    run_op(LOAD_DISABLE, STORE_SW, 32'h0000_1000, 32'hDEAD_BEEF, 5'd0, -1, ns);
    check("sw_stall", ns, 1);
    idle(1);

    // LB 0x1003, gnt on 2nd REQ cycle, rvalid one cycle later: byte 0x80
    set_bus(1, 1, 32'h80FF_FF00);
    push_load(32'h0000_1000, 5'd7, 32'hFFFF_FF80, 1'b1);
    run_op(LOAD_LB, STORE_DISABLE, 32'h0000_1003, 32'h0, 5'd7, -1, ns);
    check("lb_stall", ns, 3);
    idle(1);

    // LHU 0x2002, gnt and rvalid together: upper half zero-extended
    set_bus(0, 0, 32'hBEEF_1234);
    push_load(32'h0000_2000, 5'd8, 32'h0000_BEEF, 1'b1);
    run_op(LOAD_LHU, STORE_DISABLE, 32'h0000_2002, 32'h0, 5'd8, -1, ns);
    check("lhu_stall", ns, 1);
    idle(1);

    // SB 0x3001 with gnt withheld for 5 REQ cycles: request held stable
    set_bus(5, 0, 32'h0);
    push_store(32'h0000_3000, 4'b0010, 32'hABAB_ABAB);
    run_op(LOAD_DISABLE, STORE_SB, 32'h0000_3001, 32'h0000_00AB, 5'd0, -1, ns);
    check("sb_stall", ns, 6);
    idle(1);

    // SH 0x5002: upper lane pair
    set_bus(0, 0, 32'h0);
    push_store(32'h0000_5000, 4'b1100, 32'hCAFE_CAFE);
    run_op(LOAD_DISABLE, STORE_SH, 32'h0000_5002, 32'h0000_CAFE, 5'd0, -1, ns);
    check("sh_stall", ns, 1);
    idle(1);

    // LH 0x6002: upper half 0x8001 sign-extended
    set_bus(0, 2, 32'h8001_7FFF);
    push_load(32'h0000_6000, 5'd11, 32'hFFFF_8001, 1'b1);
    run_op(LOAD_LH, STORE_DISABLE, 32'h0000_6002, 32'h0, 5'd11, -1, ns);
    check("lh_stall", ns, 3);
    idle(1);

    // LBU 0x7001: byte 1 = 0xC3 zero-extended
    set_bus(2, 0, 32'h1234_C3A5);
    push_load(32'h0000_7000, 5'd12, 32'h0000_00C3, 1'b1);
    run_op(LOAD_LBU, STORE_DISABLE, 32'h0000_7001, 32'h0, 5'd12, -1, ns);
    check("lbu_stall", ns, 3);
    idle(1);

    // LW to x0 still writes back
    set_bus(0, 1, 32'hCAFE_F00D);
    push_load(32'h0000_7100, 5'd0, 32'hCAFE_F00D, 1'b1);
    run_op(LOAD_LW, STORE_DISABLE, 32'h0000_7100, 32'h0, 5'd0, -1, ns);
    check("lw_x0_stall", ns, 2);
    idle(1);

    // Load and store codes both active: store wins, no writeback
    set_bus(0, 0, 32'h0);
    push_store(32'h0000_8004, 4'hF, 32'h1122_3344);
    run_op(LOAD_LW, STORE_SW, 32'h0000_8004, 32'h1122_3344, 5'd4, -1, ns);
    check("both_stall", ns, 1);
    idle(1);

    // Flush in WAIT: rvalid still awaited, no writeback
    set_bus(0, 3, 32'h5555_AAAA);
    push_load(32'h0000_4000, 5'd5, 32'h0, 1'b0);
    run_op(LOAD_LW, STORE_DISABLE, 32'h0000_4000, 32'h0, 5'd5, 2, ns);
    check("flush_wait_stall", ns, 4);
    idle(1);

    // Flush in REQ before gnt: request abandoned
    set_bus(3, 0, 32'h0);
    push_store(32'h0000_9000, 4'hF, 32'h0000_0055);
    run_op(LOAD_DISABLE, STORE_SW, 32'h0000_9000, 32'h0000_0055, 5'd0, 2, ns);
    check("flush_req_stall", ns, 2);
    check("flush_req_ungranted", exp_req.size(), 1);
    if (exp_req.size() > 0) void'(exp_req.pop_front());
    idle(3);

    // Flush in IDLE: op ignored, no request
    set_bus(0, 0, 32'h0);
    run_op(LOAD_LW, STORE_DISABLE, 32'h0000_A000, 32'h0, 5'd6, 0, ns);
    check("flush_idle_stall", ns, 0);
    idle(2);

    // Timeout in WAIT (TIMEOUT_MAX = 8), late rvalid in IDLE ignored
    set_bus(0, 10, 32'h7777_7777);
    push_load(32'h0000_B000, 5'd9, 32'h0, 1'b0);
    exp_err_n++;
    run_op(LOAD_LW, STORE_DISABLE, 32'h0000_B000, 32'h0, 5'd9, -1, ns);
    check("timeout_stall", ns, 8);
    idle(6);

`ifdef MISALIGN_TRAP_EN
    // Misaligned LW/SH trap in IDLE without touching the bus
    exp_mis_n++;
    run_op(LOAD_LW, STORE_DISABLE, 32'h0000_1002, 32'h0, 5'd3, -1, ns);
    check("mis_lw_stall", ns, 0);
    idle(1);
    exp_mis_n++;
    run_op(LOAD_DISABLE, STORE_SH, 32'h0000_1001, 32'h1234, 5'd0, -1, ns);
    check("mis_sh_stall", ns, 0);
    idle(1);
`else
    // Without trapping, LW 0x1002 reads the aligned word
    set_bus(0, 0, 32'h1234_5678);
    push_load(32'h0000_1000, 5'd3, 32'h1234_5678, 1'b1);
    run_op(LOAD_LW, STORE_DISABLE, 32'h0000_1002, 32'h0, 5'd3, -1, ns);
    check("lw_unaligned_stall", ns, 1);
    idle(1);
`endif

    check("mis_pulses_seen", exp_mis_n, 0);
    check("bus_err_seen", exp_err_n, 0);
    check("req_queue_empty", exp_req.size(), 0);
    check("wb_queue_empty", exp_wb.size(), 0);

    // Short timeout instance: LW never granted, bus_err on 4th REQ cycle
    t_is_load = LOAD_LW; t_addr = 32'h0000_0100;
    ns = 0; nreq = 0; seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (t_dmem_req) nreq++;
      if (t_stall) begin
        ns++;
        check("t4_no_early_err", {31'h0, t_bus_err}, 32'h0);
      end else begin
        seen = 1'b1;
        check("t4_bus_err", {31'h0, t_bus_err}, 32'h1);
      end
      @(posedge clk); #1;
    end
    t_is_load = LOAD_DISABLE;
    check("t4_stall_cycles", ns, 4);
    check("t4_req_cycles", nreq, 4);
    @(negedge clk);
    check("t4_idle_after", {29'h0, t_dmem_req, t_stall, t_bus_err}, 32'h0);
    check("t4_no_wb", {31'h0, t_wb_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
